// File: rtl/dat_mod_pkg.sv
// Shared definitions for the dat_mod_multi symbol mapper: modulation encoding,
// 16-bit amplitude/step constants and the Gray-code level tables.
package dat_mod_pkg;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_16QAM = 2'd2,
        MOD_64QAM = 2'd3
    } mod_e;

    localparam logic signed [15:0] A1 = 16'sh7FFF;
    localparam logic signed [15:0] A2 = 16'sh5A82;
    localparam logic signed [15:0] S4 = 16'sh287A;
    localparam logic signed [15:0] S6 = 16'sh1249;

    // Levels indexed by the raw Gray code of one component.
    localparam logic signed [3:0] GRAY16_LVL [4] = '{-4'sd3, -4'sd1, 4'sd3, 4'sd1};
    localparam logic signed [3:0] GRAY64_LVL [8] = '{-4'sd7, -4'sd5, -4'sd1, -4'sd3,
                                                      4'sd7,  4'sd5,  4'sd1,  4'sd3};

endpackage

// File: rtl/qam_level_map.sv
// Combinational symbol mapper: turns the per-word bits and mode into the
// {Re, Im} amplitude pair in Q1.(W-1).
module qam_level_map
    import dat_mod_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [5:0]   i_bits,
    input  logic [1:0]   i_mode,
    output logic [W-1:0] o_re,
    output logic [W-1:0] o_im
);

    localparam int SH = 16 - W;

    localparam logic [W-1:0] A1_W = W'(A1 >>> SH);
    localparam logic [W-1:0] A2_W = W'(A2 >>> SH);
    localparam logic [W-1:0] S4_W = W'(S4 >>> SH);
    localparam logic [W-1:0] S6_W = W'(S6 >>> SH);

    // Scale |lvl| by the step, then negate exactly for negative levels.
    function automatic logic [W-1:0] lvl_scale(input logic signed [3:0] lvl,
                                                input logic [W-1:0]      step);
        logic [3:0]   mag;
        logic [W+3:0] prod;
        logic [W-1:0] pos;
        mag  = lvl[3] ? 4'(~lvl + 4'd1) : 4'(lvl);
        prod = {4'd0, step} * {{W{1'b0}}, mag};
        pos  = prod[W-1:0];
        return lvl[3] ? (~pos + {{(W-1){1'b0}}, 1'b1}) : pos;
    endfunction

    // Mode-dependent mapping; bits above those the mode uses are ignored.
    always_comb begin
        o_re = {W{1'b0}};
        o_im = {W{1'b0}};
        case (i_mode)
            MOD_BPSK: begin
                o_re = lvl_scale(i_bits[0] ? 4'sd1 : -4'sd1, A1_W);
            end
            MOD_QPSK: begin
                o_re = lvl_scale(i_bits[0] ? 4'sd1 : -4'sd1, A2_W);
                o_im = lvl_scale(i_bits[1] ? 4'sd1 : -4'sd1, A2_W);
            end
            MOD_16QAM: begin
                o_re = lvl_scale(GRAY16_LVL[i_bits[1:0]], S4_W);
                o_im = lvl_scale(GRAY16_LVL[i_bits[3:2]], S4_W);
            end
            MOD_64QAM: begin
                o_re = lvl_scale(GRAY64_LVL[i_bits[2:0]], S6_W);
                o_im = lvl_scale(GRAY64_LVL[i_bits[5:3]], S6_W);
            end
            default: begin
                o_re = {W{1'b0}};
                o_im = {W{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/dat_mod_multi.sv
// Two-stage pipelined BPSK/QPSK/16QAM/64QAM mapper between a Wishbone-style
// upstream write port and a downstream strobe/ack port with backpressure.
module dat_mod_multi
    import dat_mod_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           CLK_I,
    input  logic           RST_I,
    input  logic [5:0]     DAT_I,
    input  logic           CYC_I,
    input  logic           STB_I,
    input  logic           WE_I,
    input  logic [1:0]     MOD_I,
    output logic           ACK_O,
    output logic [2*W-1:0] DAT_O,
    output logic           CYC_O,
    output logic           STB_O,
    output logic           WE_O,
    input  logic           ACK_I
);

    logic           r_mode_arm;
    logic [1:0]     r_mode;
    logic [5:0]     r_bits;
    logic [1:0]     r_s1_mode;
    logic           r_v1;
    logic [2*W-1:0] r_dat;
    logic           r_stb;
    logic           r_cyc_d1;
    logic           r_cyc_d2;

    logic           w_halt;
    logic           w_ack;
    logic [1:0]     w_mode_eff;
    logic [W-1:0]   w_re;
    logic [W-1:0]   w_im;

    assign w_halt = r_stb & ~ACK_I;
    assign w_ack  = CYC_I & STB_I & WE_I & ~w_halt;

    // The first word of a bus cycle already uses the mode sampled in that cycle.
    assign w_mode_eff = (CYC_I && r_mode_arm) ? MOD_I : r_mode;

    // Mode is captured once per bus cycle; changes while CYC_I stays high are ignored.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_mode     <= MOD_QPSK;
            r_mode_arm <= 1'b1;
        end else if (!CYC_I) begin
            r_mode_arm <= 1'b1;
        end else if (r_mode_arm) begin
            r_mode     <= MOD_I;
            r_mode_arm <= 1'b0;
        end
    end

    // Stage 1: holds the accepted bits together with the mode they were sent under.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_bits    <= 6'd0;
            r_s1_mode <= MOD_QPSK;
            r_v1      <= 1'b0;
        end else if (w_ack) begin
            r_bits    <= DAT_I;
            r_s1_mode <= w_mode_eff;
            r_v1      <= 1'b1;
        end else if (!w_halt) begin
            r_v1      <= 1'b0;
        end
    end

    qam_level_map #(.W(W)) u_map (
        .i_bits (r_bits),
        .i_mode (r_s1_mode),
        .o_re   (w_re),
        .o_im   (w_im)
    );

    // Stage 2: output register, frozen while the downstream stalls.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_dat <= {(2*W){1'b0}};
            r_stb <= 1'b0;
        end else if (!w_halt) begin
            if (r_v1) begin
                r_dat <= {w_im, w_re};
                r_stb <= 1'b1;
            end else begin
                r_stb <= 1'b0;
            end
        end
    end

    // CYC_O follows CYC_I through the same two-edge delay as the data.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_cyc_d1 <= 1'b0;
            r_cyc_d2 <= 1'b0;
        end else begin
            r_cyc_d1 <= CYC_I;
            r_cyc_d2 <= r_cyc_d1;
        end
    end

    assign ACK_O = w_ack;
    assign DAT_O = r_dat;
    assign STB_O = r_stb;
    assign WE_O  = r_stb;
    assign CYC_O = r_cyc_d2;

endmodule

// File: tb/tb_dat_mod_multi.sv
// Directed-vector bench for dat_mod_multi (W=16): stream tables with
// hand-computed symbols, backpressure, mode capture and mid-stream reset.
module tb_dat_mod_multi;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic [5:0]  DAT_I;
    logic        CYC_I, STB_I, WE_I, ACK_I;
    logic [1:0]  MOD_I;
    logic        ACK_O, CYC_O, STB_O, WE_O;
    logic [31:0] DAT_O;

    int n_chk  = 0;
    int n_pass = 0;

    logic [5:0]  tx_dat [64];
    logic [31:0] tx_exp [64];

    always #5 CLK_I = ~CLK_I;

    dat_mod_multi #(.W(16)) dut (
        .CLK_I (CLK_I), .RST_I (RST_I), .DAT_I (DAT_I),
        .CYC_I (CYC_I), .STB_I (STB_I), .WE_I (WE_I), .MOD_I (MOD_I),
        .ACK_O (ACK_O), .DAT_O (DAT_O), .CYC_O (CYC_O), .STB_O (STB_O),
        .WE_O  (WE_O),  .ACK_I (ACK_I)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    function automatic logic [15:0] q64(input logic [2:0] c);
        int lvl;
        int v;
        case (c)
            3'b000: lvl = -7;
            3'b001: lvl = -5;
            3'b011: lvl = -3;
            3'b010: lvl = -1;
            3'b110: lvl = 1;
            3'b111: lvl = 3;
            3'b101: lvl = 5;
            3'b100: lvl = 7;
            default: lvl = 0;
        endcase
        v = lvl * 4681;
        return v[15:0];
    endfunction

    // Drives tx_dat[0..n-1] upstream and scores every downstream transfer.
    task automatic stream(input string tag, input int n, input logic [1:0] mf,
                          input logic [1:0] ml, input int st_at, input int st_len);
        int cyc, wi, ri, fa, fx, lx;
        cyc = 0; wi = 0; ri = 0; fa = -1; fx = -1; lx = -1;
        while (ri < n && cyc < 300) begin
            CYC_I = 1'b1;
            MOD_I = (cyc == 0) ? mf : ml;
            STB_I = (wi < n);
            WE_I  = STB_I;
            DAT_I = (wi < n) ? tx_dat[wi] : 6'd0;
            ACK_I = (cyc >= st_at && cyc < st_at + st_len) ? 1'b0 : 1'b1;
            #1;
            if (cyc == 1) check({tag, "_cyco_lo"}, 32'(CYC_O), 32'd0);
            if (cyc == 2) check({tag, "_cyco_hi"}, 32'(CYC_O), 32'd1);
            if (!ACK_I) begin
                check({tag, "_stall_stb"}, 32'(STB_O), 32'd1);
                check({tag, "_stall_ack"}, 32'(ACK_O), 32'd0);
                check({tag, "_stall_dat"}, DAT_O, tx_exp[ri]);
            end else if (STB_I) begin
                check({tag, "_ack"}, 32'(ACK_O), 32'd1);
            end
            if (STB_O && ACK_I) begin
                check(tag, DAT_O, tx_exp[ri]);
                if (fx < 0) fx = cyc;
                lx = cyc;
                ri++;
            end
            if (ACK_O) begin
                if (fa < 0) fa = cyc;
                wi++;
            end
            step();
            cyc++;
        end
        check({tag, "_count"}, 32'(ri), 32'(n));
        check({tag, "_latency"}, 32'(fx - fa), 32'd2);
        if (st_len == 0) check({tag, "_bubbles"}, 32'(lx - fx), 32'(n - 1));
        STB_I = 1'b0;
        WE_I  = 1'b0;
        #1;
        check({tag, "_drain"}, 32'(STB_O), 32'd0);
        CYC_I = 1'b0;
        step();
        step();
    endtask

    initial begin
        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        ACK_I = 1'b1; DAT_I = 6'd0; MOD_I = 2'd1;
        step();
        step();
        check("rst_stb",  32'(STB_O), 32'd0);
        check("rst_we",   32'(WE_O),  32'd0);
        check("rst_dat",  DAT_O,      32'd0);
        check("rst_cyco", 32'(CYC_O), 32'd0);
        check("rst_ack",  32'(ACK_O), 32'd0);
        RST_I = 1'b0;
        step();

        // QPSK 0..3 at full throughput
        tx_dat[0] = 6'd0; tx_exp[0] = 32'hA57EA57E;
        tx_dat[1] = 6'd1; tx_exp[1] = 32'hA57E5A82;
        tx_dat[2] = 6'd2; tx_exp[2] = 32'h5A82A57E;
        tx_dat[3] = 6'd3; tx_exp[3] = 32'h5A825A82;
        stream("qpsk", 4, 2'd1, 2'd1, 0, 0);

        // All 64 64QAM words; corner words pinned to hand values
        for (int i = 0; i < 64; i++) begin
            logic [5:0] b;
            b = 6'(i);
            tx_dat[i] = b;
            tx_exp[i] = {q64(b[5:3]), q64(b[2:0])};
        end
        tx_exp[36] = 32'h7FFF7FFF;
        tx_exp[0]  = 32'h80018001;
        tx_exp[9]  = 32'hA493A493;
        stream("q64", 64, 2'd3, 2'd3, 0, 0);

        // MOD_I moves 1 -> 2 inside one bus cycle: stays QPSK
        tx_dat[0] = 6'd0; tx_exp[0] = 32'hA57EA57E;
        tx_dat[1] = 6'd3; tx_exp[1] = 32'h5A825A82;
        tx_dat[2] = 6'd2; tx_exp[2] = 32'h5A82A57E;
        tx_dat[3] = 6'd1; tx_exp[3] = 32'hA57E5A82;
        stream("modtog", 4, 2'd1, 2'd2, 0, 0);

        // 16QAM after a new bus cycle, 3-cycle downstream stall mid-stream
        tx_dat[0] = 6'h00; tx_exp[0] = 32'h86928692;
        tx_dat[1] = 6'h35; tx_exp[1] = 32'hD786D786;
        tx_dat[2] = 6'h0A; tx_exp[2] = 32'h796E796E;
        tx_dat[3] = 6'h0F; tx_exp[3] = 32'h287A287A;
        tx_dat[4] = 6'h03; tx_exp[4] = 32'h8692287A;
        tx_dat[5] = 6'h0C; tx_exp[5] = 32'h287A8692;
        stream("q16", 6, 2'd2, 2'd2, 3, 3);

        // BPSK; bit1 is ignored
        tx_dat[0] = 6'd0; tx_exp[0] = 32'h00008001;
        tx_dat[1] = 6'd1; tx_exp[1] = 32'h00007FFF;
        tx_dat[2] = 6'd2; tx_exp[2] = 32'h00008001;
        stream("bpsk", 3, 2'd0, 2'd0, 0, 0);

        // Two words in flight, then a one-cycle reset
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; MOD_I = 2'd3; ACK_I = 1'b0;
        DAT_I = 6'h24;
        step();
        DAT_I = 6'h00;
        step();
        check("pre_rst_stb", 32'(STB_O), 32'd1);
        check("pre_rst_ack", 32'(ACK_O), 32'd0);
        STB_I = 1'b0; WE_I = 1'b0; RST_I = 1'b1;
        step();
        check("mid_rst_stb",  32'(STB_O), 32'd0);
        check("mid_rst_dat",  DAT_O,      32'd0);
        check("mid_rst_cyco", 32'(CYC_O), 32'd0);
        RST_I = 1'b0; CYC_I = 1'b0; ACK_I = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("no_emit", 32'(STB_O), 32'd0);
        end
        tx_dat[0] = 6'h09; tx_exp[0] = 32'hA493A493;
        stream("post_rst", 1, 2'd3, 2'd3, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dat_mod_multi.md
DAT_MOD_MULTI -- requirements
Module: dat_mod_multi

Interface
REQ-001 SHALL have parameter W, default 16, meaning output component width in bits (legal 12..16).
REQ-002 SHALL have port CLK_I  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_I  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port DAT_I  in  6  input bits for one symbol, LSB first.
REQ-005 SHALL have ports CYC_I, STB_I, WE_I  in  1 each  upstream bus cycle, strobe and write.
REQ-006 SHALL have port MOD_I  in  2  modulation select: 0=BPSK, 1=QPSK, 2=16QAM, 3=64QAM.
REQ-007 SHALL have port ACK_O  out  1  input word accepted this cycle.
REQ-008 SHALL have port DAT_O  out  2W  symbol {Im, Re}, each two's complement Q1.(W-1).
REQ-009 SHALL have ports CYC_O, STB_O, WE_O  out  1 each  downstream cycle, strobe and write; WE_O = STB_O.
REQ-010 SHALL have port ACK_I  in  1  downstream accepts DAT_O when STB_O high.

Function
REQ-011 SHALL define halt = STB_O & ~ACK_I, and ACK_O = CYC_I & STB_I & WE_I & ~halt, combinationally.
REQ-012 SHALL use stage 1 (bits, mode, valid v1): on ACK_O, load DAT_I and set v1=1; when ~halt and no ACK_O, clear v1; when halt, hold.
REQ-013 SHALL use stage 2 (output register): when v1 & ~halt, load the mapped symbol into DAT_O and set STB_O=1; when ~v1 & ~halt, clear STB_O; when halt, hold DAT_O and STB_O.
REQ-014 SHALL have latency 2 edges: a word acknowledged at edge n appears on DAT_O with STB_O=1 after edge n+1, with zero bubbles at full throughput (ACK_I held high).
REQ-015 SHALL lose and duplicate no word under any ACK_I pattern; each acknowledged word is transferred exactly once, in order.
REQ-016 SHALL latch MOD_I into the mode register on the first cycle CYC_I=1 after a cycle with CYC_I=0, or after reset; MOD_I changes while CYC_I stays high SHALL be ignored.
REQ-017 SHALL capture the mode in stage 1 with each word, so a later mode change cannot alter a word already accepted.
REQ-018 SHALL map BPSK as follows: Re = bit0 ? +A1 : -A1, Im = 0; A1 = 0x7FFF.
REQ-019 SHALL map QPSK as follows: Re from bit0, Im from bit1, value 1 -> +A2, 0 -> -A2; A2 = 0x5A82, so -A2 = 0xA57E.
REQ-020 SHALL map 16QAM as follows: Re from bits[1:0], Im from bits[3:2], Gray code 00->-3, 01->-1, 11->+1, 10->+3, times step S4 = 0x287A.
REQ-021 SHALL map 64QAM as follows: Re from bits[2:0], Im from bits[5:3], Gray code 000->-7, 001->-5, 011->-3, 010->-1, 110->+1, 111->+3, 101->+5, 100->+7, times step S6 = 0x1249, so +7 gives 0x7FFF.
REQ-022 SHALL form negative levels by exact two's-complement negation of the positive constant; saturation is never needed.
REQ-023 SHALL derive the constants for W<16 as the 16-bit constant arithmetically shifted right by 16-W.
REQ-024 SHALL ignore DAT_I bits above the bits the mode uses.
REQ-025 SHALL produce CYC_O as CYC_I delayed by exactly 2 edges.

Reset
REQ-026 SHALL, while RST_I is high at an edge, clear v1, STB_O, DAT_O (all zero), CYC_O, the CYC delay register, the stage-1 bits and mode to QPSK (1), and arm mode capture.
REQ-027 SHALL have ACK_O low during reset only through CYC/STB gating; RST_I is not in the ACK_O path.
REQ-028 SHALL, when reset occurs mid-stream, discard in-flight words; after release the first output is the first word acknowledged after reset.

Structure
REQ-029 SHALL place the mode encoding, A1/A2/S4/S6 constants and the Gray level tables in shared package dat_mod_pkg.
REQ-030 SHALL implement the mapping in combinational sub-module qam_level_map (inputs: bits, mode; outputs: Re, Im), instantiated between stage 1 and stage 2.

Verification
REQ-031 SHALL cover QPSK stream 0,1,2,3 with ACK_I=1 -> DAT_O = A57EA57E, A57E5A82, 5A82A57E, 5A825A82 on consecutive cycles, with latency 2.
REQ-032 SHALL cover all 64 64QAM words -> each Re/Im equals level*0x1249; DAT_I=6'b100100 gives 7FFF7FFF, and 6'b000000 gives 8001 in both components.
REQ-033 SHALL cover 16QAM with ACK_I held low for 3 cycles mid-stream -> STB_O and DAT_O held, ACK_O low, and no loss or duplication after release.
REQ-034 SHALL cover MOD_I toggled from 1 to 2 while CYC_I stays high -> outputs remain QPSK; after CYC_I drops and rises, 16QAM takes effect.
REQ-035 SHALL cover BPSK with DAT_I=0 and then 1 -> 0000_8001, then 0000_7FFF.
REQ-036 SHALL cover RST_I asserted for one cycle with 2 words in flight -> next edge STB_O=0, DAT_O=0, CYC_O=0, and neither word ever emitted.
